// File: rtl/vga_scanout_if.sv
// Synchronous frame-buffer read port between the scanout engine and the video buffer.
// The scanout side drives the address; the buffer returns data one clock later.
interface vga_scanout_if;
  logic [18:0] read_addr;
  logic [11:0] read_data;

  modport master (
    output read_addr,
    input  read_data
  );

  modport slave (
    input  read_addr,
    output read_data
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA raster generator and frame-buffer scanout: pixel-enable divider, h/v counters,
// registered read address and a pixel-rate output stage with colour and syncs aligned.
module vga_scanout #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_scanout_if.master        fb,
  output logic                 hsync,
  output logic                 vsync,
  output logic [11:0]          rgb,
  output logic                 video_on,
  output logic                 frame_start,
  output logic                 p_tick
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] d_q, d_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [18:0]   addr_q, addr_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          frame_start_q, frame_start_d;

  logic [31:0]   h_ext, v_ext;
  logic          vis, in_hsync, in_vsync, at_origin;
  logic [18:0]   pix_addr;

  assign p_tick = (d_q == DW'(CLK_DIV - 1));

  // Compare in 32 bits so sync windows ending exactly at the total cannot alias.
  assign h_ext     = 32'(h_q);
  assign v_ext     = 32'(v_q);
  assign vis       = (h_ext < H_DISPLAY) && (v_ext < V_DISPLAY);
  assign in_hsync  = (h_ext >= HS_START) && (h_ext < HS_END);
  assign in_vsync  = (v_ext >= VS_START) && (v_ext < VS_END);
  assign at_origin = (h_q == '0) && (v_q == '0);

  // Constant multiply; for a 640-wide raster this reduces to (v<<9)+(v<<7).
  assign pix_addr = 19'(v_q) * 19'(H_DISPLAY) + 19'(h_q);

  always_comb begin
    d_d = p_tick ? '0 : d_q + 1'b1;
    h_d = h_q;
    v_d = v_q;
    if (p_tick) begin
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    addr_d = vis ? pix_addr : '0;
  end

  // Output stage samples the counters one pixel period after they moved, by which time
  // the read issued for that pixel has returned.
  always_comb begin
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    if (p_tick) begin
      rgb_d         = vis ? fb.read_data : 12'h000;
      hsync_d       = !in_hsync;
      vsync_d       = !in_vsync;
      video_on_d    = vis;
      frame_start_d = at_origin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q           <= '0;
      h_q           <= '0;
      v_q           <= '0;
      addr_q        <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      d_q           <= d_d;
      h_q           <= h_d;
      v_q           <= v_d;
      addr_q        <= addr_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb.read_addr = addr_q;
  assign rgb          = rgb_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_on     = video_on_q;
  assign frame_start  = frame_start_q;

endmodule
